// File: rtl/playback_pkg.sv
// playback_pkg
//   Shared definitions for the music-playback beat datapath: the sequencer
//   state encoding, beat/track widths, and the default tempo and song-length
//   constants also used by the note ROM and the tone generator.
package playback_pkg;

  // Fixed 2-bit encoding; the value is exported on the sequencer's state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IBEAT_W = 12;
  localparam int TRACK_W = 2;

  // 8 beats/s at 100 MHz; a 4095-beat song.
  localparam int DEF_DIV   = 12500000;
  localparam int DEF_LEN   = 4095;
  localparam int DEF_DIV_W = 25;

endpackage

// File: rtl/beat_divider.sv
// beat_divider
//   Beat-rate divider. Counts clk cycles while en is high and flags the
//   cycle in which the current beat period expires.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     en         : advance the counter this cycle (hold when low)
//     clr        : restart the period (count <= 0); overrides en
//     slow       : 1 = period of 2*DIV cycles, 0 = DIV cycles
//     tick       : combinational; high while count has reached the limit.
//                  The counter wraps on the following edge only if en=1.
module beat_divider
  import playback_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic slow,
  output logic tick
);

  localparam logic [DIV_W-1:0] LIM_FAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] LIM_SLOW = DIV_W'(2 * DIV - 1);

  logic [DIV_W-1:0] count_reg;
  logic [DIV_W-1:0] count_next;
  logic [DIV_W-1:0] limit;

  assign limit = slow ? LIM_SLOW : LIM_FAST;

  // >= rather than == so that dropping from slow to fast tempo past the
  // fast limit expires the period at once instead of running to wrap.
  assign tick = (count_reg >= limit);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = tick ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/playback_sequencer.sv
// playback_sequencer
//   Play/pause/stop/loop sequencer for the playback beat datapath. Owns the
//   beat index that addresses the note ROM and the latched track number.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     start_p    : pulse; start from IDLE/DONE, resume from PAUSE
//     pause_p    : pulse; toggle PLAY <-> PAUSE
//     stop_p     : pulse; back to IDLE with ibeat cleared
//     slow       : level; half tempo
//     loop_en    : level; wrap to beat 0 at end of song
//     track_sel  : track requested, captured only when starting
//     ibeat      : current beat index (0..LEN-1)
//     track      : latched active track
//     beat_tick  : pulse, aligned with each new ibeat value
//     playing    : 1 while in PLAY
//     state      : IDLE=0 PLAY=1 PAUSE=2 DONE=3
//     song_done  : pulse when the last beat expires
//   All outputs are registered.
module playback_sequencer
  import playback_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int LEN   = DEF_LEN,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_p,
  input  logic               pause_p,
  input  logic               stop_p,
  input  logic               slow,
  input  logic               loop_en,
  input  logic [TRACK_W-1:0] track_sel,
  output logic [IBEAT_W-1:0] ibeat,
  output logic [TRACK_W-1:0] track,
  output logic               beat_tick,
  output logic               playing,
  output logic [1:0]         state,
  output logic               song_done
);

  localparam logic [IBEAT_W-1:0] LAST_BEAT = IBEAT_W'(LEN - 1);

  state_t             state_reg, state_next;
  logic [IBEAT_W-1:0] ibeat_reg, ibeat_next;
  logic [TRACK_W-1:0] track_reg, track_next;
  logic               beat_tick_reg, beat_tick_next;
  logic               song_done_reg, song_done_next;
  logic               playing_reg;

  logic div_en;
  logic div_clr;
  logic div_tick;

  beat_divider #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_beat_divider (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .clr   (div_clr),
    .slow  (slow),
    .tick  (div_tick)
  );

  // Command priority: stop > start > pause. Only the highest-priority pulse
  // present is acted on; the others are dropped.
  always_comb begin
    state_next     = state_reg;
    ibeat_next     = ibeat_reg;
    track_next     = track_reg;
    beat_tick_next = 1'b0;
    song_done_next = 1'b0;
    div_en         = 1'b0;
    div_clr        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (stop_p) begin
          div_clr = 1'b1;
        end else if (start_p) begin
          state_next = PLAY;
          track_next = track_sel;
          ibeat_next = '0;
          div_clr    = 1'b1;
        end
      end

      PLAY: begin
        if (stop_p) begin
          state_next = IDLE;
          ibeat_next = '0;
          div_clr    = 1'b1;
        end else if (start_p) begin
          // Start while playing is a no-op, but it still outranks pause,
          // so playback simply continues.
          div_en = 1'b1;
          if (div_tick) begin
            if (ibeat_reg < LAST_BEAT) begin
              ibeat_next     = ibeat_reg + 1'b1;
              beat_tick_next = 1'b1;
            end else if (loop_en) begin
              ibeat_next     = '0;
              beat_tick_next = 1'b1;
              song_done_next = 1'b1;
            end else begin
              state_next     = DONE;
              song_done_next = 1'b1;
            end
          end
        end else if (pause_p) begin
          // Divider is frozen (en low), so a tick due this cycle stays
          // pending and fires on the first cycle after resume.
          state_next = PAUSE;
        end else begin
          div_en = 1'b1;
          if (div_tick) begin
            if (ibeat_reg < LAST_BEAT) begin
              ibeat_next     = ibeat_reg + 1'b1;
              beat_tick_next = 1'b1;
            end else if (loop_en) begin
              ibeat_next     = '0;
              beat_tick_next = 1'b1;
              song_done_next = 1'b1;
            end else begin
              state_next     = DONE;
              song_done_next = 1'b1;
            end
          end
        end
      end

      PAUSE: begin
        if (stop_p) begin
          state_next = IDLE;
          ibeat_next = '0;
          div_clr    = 1'b1;
        end else if (start_p || pause_p) begin
          state_next = PLAY;
        end
      end

      DONE: begin
        if (stop_p) begin
          state_next = IDLE;
          ibeat_next = '0;
          div_clr    = 1'b1;
        end else if (start_p) begin
          state_next = PLAY;
          track_next = track_sel;
          ibeat_next = '0;
          div_clr    = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        ibeat_next = '0;
        div_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      ibeat_reg     <= '0;
      track_reg     <= '0;
      beat_tick_reg <= 1'b0;
      song_done_reg <= 1'b0;
      playing_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ibeat_reg     <= ibeat_next;
      track_reg     <= track_next;
      beat_tick_reg <= beat_tick_next;
      song_done_reg <= song_done_next;
      playing_reg   <= (state_next == PLAY);
    end
  end

  assign state     = state_reg;
  assign ibeat     = ibeat_reg;
  assign track     = track_reg;
  assign beat_tick = beat_tick_reg;
  assign song_done = song_done_reg;
  assign playing   = playing_reg;

endmodule

// File: tb/tb_playback_sequencer.sv
// tb_playback_sequencer
//   Directed bench for playback_sequencer with DIV=4, LEN=8. Inputs change
//   and outputs are sampled 1 time unit after each rising edge.
module tb_playback_sequencer;

  localparam int DIV   = 4;
  localparam int LEN   = 8;
  localparam int DIV_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_p, pause_p, stop_p, slow, loop_en;
  logic [1:0]  track_sel;
  logic [11:0] ibeat;
  logic [1:0]  track;
  logic        beat_tick, playing, song_done;
  logic [1:0]  state;

  int n_vec  = 0;
  int n_miss = 0;

  playback_sequencer #(
    .DIV   (DIV),
    .LEN   (LEN),
    .DIV_W (DIV_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_p   (start_p),
    .pause_p   (pause_p),
    .stop_p    (stop_p),
    .slow      (slow),
    .loop_en   (loop_en),
    .track_sel (track_sel),
    .ibeat     (ibeat),
    .track     (track),
    .beat_tick (beat_tick),
    .playing   (playing),
    .state     (state),
    .song_done (song_done)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_p = 1'b1; step(1); start_p = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_p = 1'b1; step(1); pause_p = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_p = 0; pause_p = 0; stop_p = 0;
    slow = 0; loop_en = 0; track_sel = 2'd0;
    step(2);
    check_vec("rst_state", state, 0);
    check_vec("rst_ibeat", ibeat, 0);
    check_vec("rst_playing", playing, 0);
    check_vec("rst_tick", beat_tick, 0);
    reset = 1'b0;
    step(1);

    // Normal run: beat every 4 cycles, ends in DONE holding beat 7.
    track_sel = 2'd2;
    pulse_start();
    check_vec("run_state", state, 1);
    check_vec("run_playing", playing, 1);
    check_vec("run_track", track, 2);
    check_vec("run_ibeat0", ibeat, 0);
    for (int b = 1; b <= 7; b++) begin
      step(3);
      check_vec("run_no_tick", beat_tick, 0);
      step(1);
      check_vec("run_tick", beat_tick, 1);
      check_vec("run_ibeat", ibeat, b);
    end
    step(3);
    check_vec("run_pre_done", state, 1);
    step(1);
    check_vec("done_state", state, 3);
    check_vec("done_pulse", song_done, 1);
    check_vec("done_no_tick", beat_tick, 0);
    check_vec("done_ibeat", ibeat, 7);
    check_vec("done_playing", playing, 0);
    step(1);
    check_vec("done_pulse_end", song_done, 0);

    // pause in DONE is ignored; restart from DONE relatches track.
    pulse_pause();
    check_vec("done_pause_ign", state, 3);
    track_sel = 2'd1;
    pulse_start();
    check_vec("restart_state", state, 1);
    check_vec("restart_ibeat", ibeat, 0);
    check_vec("restart_track", track, 1);

    // track_sel changes while playing are ignored.
    track_sel = 2'd3;
    step(4);
    check_vec("trk_hold_tick", beat_tick, 1);
    check_vec("trk_hold_ibeat", ibeat, 1);
    check_vec("trk_hold", track, 1);

    // Pause 2 cycles after a tick, hold 10, resume: tick 2 cycles later.
    step(2);
    pulse_pause();
    check_vec("pause_state", state, 2);
    step(10);
    check_vec("pause_hold_state", state, 2);
    check_vec("pause_hold_ibeat", ibeat, 1);
    pulse_pause();
    check_vec("resume_state", state, 1);
    step(1);
    check_vec("resume_no_tick", beat_tick, 0);
    step(1);
    check_vec("resume_tick", beat_tick, 1);
    check_vec("resume_ibeat", ibeat, 2);

    // Pause in the tick cycle: no advance, tick fires right after resume.
    step(3);
    pulse_pause();
    check_vec("ptick_state", state, 2);
    check_vec("ptick_ibeat", ibeat, 2);
    check_vec("ptick_no_tick", beat_tick, 0);
    pulse_start();
    check_vec("ptick_resume", state, 1);
    step(1);
    check_vec("ptick_late_tick", beat_tick, 1);
    check_vec("ptick_late_ibeat", ibeat, 3);

    // start+stop together in PLAY: stop wins.
    start_p = 1'b1; stop_p = 1'b1;
    step(1);
    start_p = 1'b0; stop_p = 1'b0;
    check_vec("ss_state", state, 0);
    check_vec("ss_ibeat", ibeat, 0);
    check_vec("ss_playing", playing, 0);

    // Asynchronous reset mid-play at ibeat=5.
    track_sel = 2'd2;
    pulse_start();
    step(20);
    check_vec("mid_ibeat", ibeat, 5);
    #2 reset = 1'b1;
    #1;
    check_vec("arst_state", state, 0);
    check_vec("arst_ibeat", ibeat, 0);
    check_vec("arst_track", track, 0);
    check_vec("arst_playing", playing, 0);
    step(1);
    reset = 1'b0;
    step(1);

    // Loop at half tempo: ticks every 8, 7->0 wraps with song_done.
    loop_en = 1'b1; slow = 1'b1; track_sel = 2'd0;
    pulse_start();
    for (int b = 1; b <= 7; b++) begin
      step(8);
      check_vec("slow_ibeat", ibeat, b);
    end
    step(8);
    check_vec("wrap_ibeat", ibeat, 0);
    check_vec("wrap_done", song_done, 1);
    check_vec("wrap_tick", beat_tick, 1);
    check_vec("wrap_state", state, 1);
    // Clear slow at count=6: tick on the very next cycle.
    step(6);
    check_vec("s2f_no_tick", beat_tick, 0);
    slow = 1'b0;
    step(1);
    check_vec("s2f_tick", beat_tick, 1);
    check_vec("s2f_ibeat", ibeat, 1);
    step(4);
    check_vec("fast_ibeat", ibeat, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/playback_sequencer.md
Name: playback_sequencer

Overview:
Controls the music-playback beat datapath of the TypeRacer audio path. Sequences play, pause, stop, slow tempo and looping, generates the beat-rate tick, and owns the beat index (ibeat) that addresses the note ROM. Sits between the debounced, one-pulsed button/switch front end and the note ROM / tone generator.

Parameters:
DIV, 12500000, clk cycles per beat at normal tempo (8 beats/s at 100 MHz); must be >= 2.
LEN, 4095, song length in beats; ibeat range 0..LEN-1; must be 2..4096.
DIV_W, 25, divider counter width; must hold 2*DIV-1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_p  in  1  one-cycle pulse: start from IDLE/DONE, or resume from PAUSE
pause_p  in  1  one-cycle pulse: toggles PLAY <-> PAUSE
stop_p  in  1  one-cycle pulse: return to IDLE, ibeat cleared
slow  in  1  level; 1 = half tempo (period 2*DIV)
loop_en  in  1  level; 1 = wrap to beat 0 at end of song
track_sel  in  2  requested track; sampled only on start from IDLE/DONE
ibeat  out  12  current beat index to note ROM
track  out  2  latched active track
beat_tick  out  1  one-cycle pulse on every beat advance
playing  out  1  1 iff state == PLAY
state  out  2  IDLE=0, PLAY=1, PAUSE=2, DONE=3
song_done  out  1  one-cycle pulse when last beat expires

Behaviour:
- Reset (async): state=IDLE, ibeat=0, track=0, divider count=0; beat_tick=song_done=playing=0.
- All outputs registered; reset value is the only asynchronous behaviour.
- Command priority within one cycle: stop_p > start_p > pause_p; lower-priority pulses in the same cycle are dropped.
- Transitions:
  - IDLE: start_p -> PLAY; latch track<=track_sel, ibeat<=0, count<=0.
  - PLAY: stop_p -> IDLE (ibeat<=0, count<=0); pause_p -> PAUSE; start_p ignored.
  - PAUSE: pause_p or start_p -> PLAY; stop_p -> IDLE. ibeat and count hold, so the beat phase is preserved across pause.
  - DONE: start_p -> PLAY (relatch track, ibeat<=0, count<=0); stop_p -> IDLE; pause_p ignored.
- Divider (PLAY only):
  - limit = slow ? 2*DIV-1 : DIV-1.
  - If count >= limit, then count<=0 and tick; else count<=count+1.
  - The >= compare makes a slow->fast change mid-period tick on the next cycle, with no overshoot or wrap.
  - First tick after a start occurs DIV cycles after the start cycle at normal tempo.
- On a tick: beat_tick=1 on the following cycle, aligned with the updated ibeat.
  - If ibeat < LEN-1: ibeat<=ibeat+1.
  - If ibeat == LEN-1 and loop_en=1: ibeat<=0, song_done pulses, stay in PLAY.
  - If ibeat == LEN-1 and loop_en=0: state<=DONE, ibeat holds LEN-1, song_done pulses, no beat_tick.
- A stop_p or pause_p in the same cycle as a tick wins: no advance and no pulses that cycle.
- track_sel changes outside a start command have no effect.
- ibeat is never >= LEN.

Decomposition:
- Shared package playback_pkg:
  - state enum (IDLE, PLAY, PAUSE, DONE) with fixed 2-bit encoding.
  - IBEAT_W=12, TRACK_W=2.
  - Default DIV/LEN constants, shared with the note ROM and the tone generator.
- One sub-module, beat_divider: DIV_W counter with inputs en, clr, slow and output tick; reused by the metronome.
- The FSM and ibeat register stay in playback_sequencer.

Test Plan:
- Reset mid-play (DIV=4, LEN=8): assert reset while ibeat=5 -> all outputs 0 immediately (async), state=IDLE.
- Normal run (DIV=4, LEN=8, slow=0, loop_en=0): start_p with track_sel=2 -> track=2; beat_tick every 4 cycles, ibeat 0..7; after beat 7 expires song_done pulses once, state=DONE, ibeat stays 7.
- Loop and slow (loop_en=1, slow=1): ticks every 8 cycles; 7 -> 0 wrap with song_done=1, state stays PLAY. Clearing slow mid-period at count=6 -> tick on the next cycle.
- Pause phase (DIV=4): pause_p 2 cycles after a tick, hold 10 cycles, then pause_p -> next tick exactly 2 cycles after resume; ibeat unchanged during PAUSE.
- Simultaneous commands: start_p+stop_p in PLAY -> IDLE, ibeat=0. pause_p in a tick cycle -> PAUSE with no advance. track_sel changed during PLAY -> track unchanged.
- Restart from DONE with track_sel=1 -> PLAY, ibeat=0, track=1; pause_p in DONE -> ignored.
